// File: rtl/dma_channel_sched_if.sv
// ---------------------------------------------------------------------------
// dma_channel_sched_if
//   Bundles the channel-side request/command/response signals and the
//   copy-engine command/handshake signals of the DMA channel scheduler.
//
//   Channel side : ch_req, ch_src, ch_dst, ch_len  (to scheduler)
//                  ch_done, ch_err                 (from scheduler)
//   Engine side  : eng_start, eng_src, eng_dst, eng_len, eng_abort
//                  (from scheduler), eng_done (to scheduler)
//   Status       : busy, cur_ch (from scheduler)
//
//   Modports: master = the scheduler, slave = channels + engine.
// ---------------------------------------------------------------------------
interface dma_channel_sched_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH*ADDR_W-1:0] ch_src;
  logic [NUM_CH*ADDR_W-1:0] ch_dst;
  logic [NUM_CH*LEN_W-1:0]  ch_len;
  logic [NUM_CH-1:0]        ch_done;
  logic [NUM_CH-1:0]        ch_err;
  logic                     eng_start;
  logic [ADDR_W-1:0]        eng_src;
  logic [ADDR_W-1:0]        eng_dst;
  logic [LEN_W-1:0]         eng_len;
  logic                     eng_done;
  logic                     eng_abort;
  logic                     busy;
  logic [CH_W-1:0]          cur_ch;

  modport master (
    input  ch_req, ch_src, ch_dst, ch_len, eng_done,
    output ch_done, ch_err, eng_start, eng_src, eng_dst, eng_len,
           eng_abort, busy, cur_ch
  );

  modport slave (
    output ch_req, ch_src, ch_dst, ch_len, eng_done,
    input  ch_done, ch_err, eng_start, eng_src, eng_dst, eng_len,
           eng_abort, busy, cur_ch
  );
endinterface

// File: rtl/dma_channel_sched.sv
// ---------------------------------------------------------------------------
// dma_channel_sched
//   Round-robin scheduler sharing one DMA copy engine among NUM_CH channels.
//   A winner's command is latched and issued to the engine with a one-cycle
//   start strobe; the engine's done (or a watchdog timeout, which aborts the
//   engine) is reported back to the winning channel as a one-cycle pulse.
//
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous active-high reset
//     bus  - dma_channel_sched_if.master (channel + engine signals)
//   All outputs are registered.
// ---------------------------------------------------------------------------
module dma_channel_sched #(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  dma_channel_sched_if.master bus
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COMPLETE,
    S_ABORT
  } state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              start_q, start_d;
  logic              abort_q, abort_d;
  logic              busy_q, busy_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] err_q, err_d;

  // Unflattened per-channel commands.
  logic [ADDR_W-1:0] req_src [NUM_CH];
  logic [ADDR_W-1:0] req_dst [NUM_CH];
  logic [LEN_W-1:0]  req_len [NUM_CH];

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      req_src[i] = bus.ch_src[i*ADDR_W +: ADDR_W];
      req_dst[i] = bus.ch_dst[i*ADDR_W +: ADDR_W];
      req_len[i] = bus.ch_len[i*LEN_W +: LEN_W];
    end
  end

  // Round-robin arbiter: first request at or after rr_ptr, wrapping.
  logic            grant_vld;
  logic [CH_W-1:0] grant_idx;

  always_comb begin
    int              sum;
    logic [CH_W-1:0] idx;
    // NOTE: every combinational output gets a default before any branch,
    // otherwise paths that skip an assignment infer a latch.
    grant_vld = 1'b0;
    grant_idx = '0;
    sum       = 0;
    idx       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum = int'(rr_ptr_q) + k;
      if (sum >= NUM_CH) sum = sum - NUM_CH;
      idx = CH_W'(sum);
      if (!grant_vld && bus.ch_req[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  logic [CH_W-1:0] rr_after_cur;
  assign rr_after_cur = (cur_ch_q == CH_LAST) ? '0 : cur_ch_q + CH_W'(1);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cur_ch_d = cur_ch_q;
    cnt_d    = cnt_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    start_d  = 1'b0;
    abort_d  = 1'b0;
    done_d   = '0;
    err_d    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          cur_ch_d = grant_idx;
          src_d    = req_src[grant_idx];
          dst_d    = req_dst[grant_idx];
          len_d    = req_len[grant_idx];
          state_d  = (req_len[grant_idx] == '0) ? S_COMPLETE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Engine completion is reported straight from this edge so the
        // channel sees done one cycle after eng_done; done beats timeout.
        if (bus.eng_done) begin
          done_d[cur_ch_q] = 1'b1;
          state_d          = S_COMPLETE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ABORT;
        end
      end
      S_COMPLETE: begin
        // Zero-length commands never reach WAIT, so their done is raised here.
        if (len_q == '0) done_d[cur_ch_q] = 1'b1;
        rr_ptr_d = rr_after_cur;
        state_d  = S_IDLE;
      end
      S_ABORT: begin
        abort_d         = 1'b1;
        err_d[cur_ch_q] = 1'b1;
        rr_ptr_d        = rr_after_cur;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      cur_ch_q <= '0;
      cnt_q    <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      start_q  <= 1'b0;
      abort_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cur_ch_q <= cur_ch_d;
      cnt_q    <= cnt_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      start_q  <= start_d;
      abort_q  <= abort_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.ch_done   = done_q;
  assign bus.ch_err    = err_q;
  assign bus.eng_start = start_q;
  assign bus.eng_src   = src_q;
  assign bus.eng_dst   = dst_q;
  assign bus.eng_len   = len_q;
  assign bus.eng_abort = abort_q;
  assign bus.busy      = busy_q;
  assign bus.cur_ch    = cur_ch_q;
endmodule

// File: doc/dma_channel_sched.md
Name: dma_channel_sched

Overview:
- Round-robin scheduler that shares the single DMA copy engine (AXI master read/write path) between NUM_CH requesting channels.
- Each channel presents a copy command (src, dst, len) with a level request.
- The scheduler picks a winner, issues the command to the engine with a start pulse, and waits for the engine's done.
- It then returns done or error to that channel. A watchdog aborts any engine transfer that does not complete within TIMEOUT cycles.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- ADDR_W, 32, byte address width of src/dst.
- LEN_W, 16, transfer length width in bytes.
- TIMEOUT, 1024, max cycles in WAIT before abort (>=2).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ch_req  in  NUM_CH  per-channel request; level, held until ch_done or ch_err for that channel.
- ch_src  in  NUM_CH*ADDR_W  flattened source addresses; channel i at [i*ADDR_W +: ADDR_W].
- ch_dst  in  NUM_CH*ADDR_W  flattened destination addresses.
- ch_len  in  NUM_CH*LEN_W  flattened byte lengths.
- ch_done  out  NUM_CH  one-cycle completion pulse to the granted channel.
- ch_err  out  NUM_CH  one-cycle timeout-abort pulse to the granted channel.
- eng_start  out  1  one-cycle command strobe to the engine.
- eng_src  out  ADDR_W  latched source address.
- eng_dst  out  ADDR_W  latched destination address.
- eng_len  out  LEN_W  latched length.
- eng_done  in  1  engine completion pulse.
- eng_abort  out  1  one-cycle abort strobe to the engine.
- busy  out  1  high in any state other than IDLE.
- cur_ch  out  $clog2(NUM_CH)  index of the current or last granted channel.

Behaviour:
- **Reset (async, rst=1):**
  - state=IDLE, rr_ptr=0, cur_ch=0, timeout counter=0.
  - All outputs 0, including eng_src/dst/len.
  - Reset mid-transfer drops the transfer silently: no done, no err, no abort.
- **Registered outputs:** all outputs are registered; no combinational path from inputs to outputs.
- **Arbitration (combinational, used only in IDLE):**
  - Scan ch_req starting at rr_ptr, ascending modulo NUM_CH; the first set bit wins.
- **IDLE:**
  - No request: stay in IDLE.
  - Request present: latch winner into cur_ch and its src/dst/len into eng_*.
  - If the winner's len==0, go to COMPLETE (engine is never started).
  - Otherwise go to ISSUE.
- **ISSUE:**
  - eng_start=1 for exactly this cycle; clear the counter; go to WAIT.
  - eng_src/dst/len stay stable from ISSUE until the next grant.
- **WAIT:**
  - Counter increments each cycle.
  - eng_done=1: go to COMPLETE.
  - Else if counter==TIMEOUT-1: go to ABORT.
  - eng_done and timeout in the same cycle: done wins.
- **COMPLETE:** ch_done[cur_ch]=1 for one cycle; rr_ptr=(cur_ch+1) mod NUM_CH; go to IDLE.
- **ABORT:** eng_abort=1 and ch_err[cur_ch]=1 for one cycle; rr_ptr=(cur_ch+1) mod NUM_CH; go to IDLE.
- **Ignored inputs:**
  - eng_done outside WAIT is ignored.
  - ch_req changes outside IDLE are ignored.
  - A request dropped after grant does not cancel the transfer.
- **Latency:**
  - req seen in IDLE at cycle N -> eng_start at N+2 (ISSUE state registered at N+1, strobe output at N+2).
  - eng_done at cycle M -> ch_done at M+1; earliest re-arbitration at M+2.
  - Zero-length: req at N -> ch_done at N+2.
- **Fairness:** a continuously requesting channel waits at most NUM_CH-1 grants.
- **Requester contract:** deassert req in the cycle after seeing ch_done or ch_err to avoid re-arbitration. The rotated rr_ptr already prevents immediate re-grant while others request.
- **Width rules:** the counter is $clog2(TIMEOUT) bits wide and saturation is never reached. No arithmetic is applied to len or addresses.

Test Plan:
- **Single channel:** ch_req=4'b0010, src=0x00, dst=0x04, len=8; engine returns eng_done 5 cycles after eng_start -> eng_start once with eng_src=0x00, eng_dst=0x04, eng_len=8, cur_ch=1; ch_done=4'b0010 one cycle after eng_done; busy low afterwards.
- **Round-robin:** ch_req=4'b1111 held, each requester dropping its req after its done, engine done 3 cycles after each start -> grant order 0,1,2,3. Then reassert ch_req=4'b1001 -> ch0 granted (rr_ptr wrapped to 0). Then reassert 4'b1001 -> ch3 granted.
- **Timeout:** TIMEOUT=16, eng_done never asserted -> eng_abort and ch_err[cur_ch] pulse exactly 17 cycles after eng_start (16 WAIT + ABORT); no ch_done; next channel is arbitrated afterwards.
- **Zero length and done-vs-timeout:**
  - ch_len=0 on ch2 -> no eng_start; ch_done[2] two cycles after req.
  - Separately, eng_done asserted on the final WAIT cycle -> ch_done, no abort.
- **Reset mid-transfer:** rst pulsed while in WAIT -> all outputs 0 immediately (async); no done or err; after release with ch_req=4'b0100, ch2 is granted from rr_ptr=0.
- **Spurious done:** eng_done pulsed in IDLE with no requests -> no ch_done, state stays IDLE.
